muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit for the RISC-V core. It sits directly downstream of the register file. It consumes the two read-port operands, runs a 32-step shift-add multiply or restoring divide, and produces a single-cycle write-back pulse. Its `result`, `rd_out` and `done` outputs drive the register file's `writeData`, `WD` and `wd` inputs. Core control holds the PC and issue while `busy` is high.

---
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit (32-step shift-add multiply,
//            restoring divide) with a single-cycle write-back pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam logic [1:0]      c_IDLE = 2'd0;
  localparam logic [1:0]      c_BUSY = 2'd1;
  localparam logic [1:0]      c_DONE = 2'd2;
  localparam logic [XLEN-1:0] c_ONES = '1;
  localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [4:0]      c_LAST = 5'd31;

  logic [1:0]        r_state;
  logic [4:0]        r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [4:0]        r_rd;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;

  logic            w_sdiv, w_s1, w_s2, w_neg, w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_mag1, w_mag2, w_spec_res;

  always_comb begin
    w_sdiv   = funct3[2] & ~funct3[0];
    w_s1     = rs1_data[XLEN-1] & (w_sdiv | (funct3 == 3'b001) | (funct3 == 3'b010));
    w_s2     = rs2_data[XLEN-1] & (w_sdiv | (funct3 == 3'b001));
    w_mag1   = w_s1 ? -rs1_data : rs1_data;
    w_mag2   = w_s2 ? -rs2_data : rs2_data;
    // Remainder takes the dividend's sign; everything else the XOR of both.
    w_neg    = (funct3[2] & funct3[1]) ? w_s1 : (w_s1 ^ w_s2);
    w_div0   = funct3[2] & (rs2_data == '0);
    w_ovf    = w_sdiv & (rs1_data == c_MIN) & (rs2_data == c_ONES);
    w_special = w_div0 | w_ovf;
    if (w_div0) w_spec_res = funct3[1] ? rs1_data : c_ONES;
    else        w_spec_res = funct3[1] ? '0 : c_MIN;
  end

  logic [XLEN:0]     w_mul_sum, w_rem_sh;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub, w_quot_res, w_rem_res, w_fin;
  logic [2*XLEN-1:0] w_acc_nxt, w_prod;

  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    // Divide keeps {remainder, quotient} in r_acc; shifted remainder needs a 33rd bit.
    w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    w_ge      = (w_rem_sh >= {1'b0, r_b});
    w_rem_sub = w_rem_sh[XLEN-1:0] - r_b;
    if (r_op[2]) w_acc_nxt = {(w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
    else         w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    w_prod     = r_neg ? -w_acc_nxt : w_acc_nxt;
    w_quot_res = r_neg ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
    w_rem_res  = r_neg ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
    if (r_op[2])              w_fin = r_op[1] ? w_rem_res : w_quot_res;
    else if (r_op[1:0] == 2'b00) w_fin = w_prod[XLEN-1:0];
    else                      w_fin = w_prod[2*XLEN-1:XLEN];
  end

  assign busy = (r_state != c_IDLE);
  assign done = (r_state == c_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_neg   <= 1'b0;
      r_rd    <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_op  <= funct3;
            r_neg <= w_neg;
            r_rd  <= rd_addr;
            r_b   <= w_mag2;
            r_acc <= {{XLEN{1'b0}}, w_mag1};
            r_cnt <= '0;
            if (w_special) begin
              result  <= w_spec_res;
              rd_out  <= rd_addr;
              r_state <= c_DONE;
            end else begin
              r_state <= c_BUSY;
            end
          end
        end
        c_BUSY: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == c_LAST) begin
            result  <= w_fin;
            rd_out  <= r_rd;
            r_state <= c_DONE;
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench for muldiv_unit against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    r   = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ovf) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (ovf) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issues one op and follows it to completion; lat counts edges after the start edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output int busyc,
                       output logic [31:0] res, output logic [4:0] rdo,
                       output logic busy_after, output logic done_after);
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busyc = 0;
    while (!done && lat < 100) begin
      if (busy) busyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) busyc++;
    res = result;
    rdo = rd_out;
    @(posedge clk); #1;
    busy_after = busy;
    done_after = done;
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b exp 0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h exp 0", result); end
    total++; if (rd_out !== 5'd0) begin bad++; $display("FAIL reset_rd_out: got %h exp 0", rd_out); end
  endtask

  task automatic test_mul();
    logic [2:0]  f [4];
    logic [31:0] a [4], b [4], e [4];
    int lat, bc; logic [31:0] res; logic [4:0] rdo; logic ba, da;
    f = '{3'd0, 3'd1, 3'd3, 3'd2};
    a = '{32'h7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    b = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    e = '{32'hFFFF_FFEB, 32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], 5'(5 + i), lat, bc, res, rdo, ba, da);
      total++; if (res !== e[i]) begin bad++; $display("FAIL mul_result[%0d]: got %h exp %h", i, res, e[i]); end
      total++; if (rdo !== 5'(5 + i)) begin bad++; $display("FAIL mul_rd[%0d]: got %0d exp %0d", i, rdo, 5 + i); end
      total++; if (lat != 32) begin bad++; $display("FAIL mul_latency[%0d]: got %0d exp 32", i, lat); end
      total++; if (bc != 33) begin bad++; $display("FAIL mul_busy_cycles[%0d]: got %0d exp 33", i, bc); end
      total++; if (ba !== 1'b0 || da !== 1'b0) begin bad++; $display("FAIL mul_after[%0d]: busy %b done %b exp 0 0", i, ba, da); end
      total++; if (result !== e[i]) begin bad++; $display("FAIL mul_hold[%0d]: got %h exp %h", i, result, e[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  f [4];
    logic [31:0] a [4], b [4], e [4];
    int lat, bc; logic [31:0] res; logic [4:0] rdo; logic ba, da;
    f = '{3'd4, 3'd6, 3'd5, 3'd7};
    a = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    b = '{32'd2, 32'd2, 32'd7, 32'd7};
    e = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], 5'(20 + i), lat, bc, res, rdo, ba, da);
      total++; if (res !== e[i]) begin bad++; $display("FAIL div_result[%0d]: got %h exp %h", i, res, e[i]); end
      total++; if (rdo !== 5'(20 + i)) begin bad++; $display("FAIL div_rd[%0d]: got %0d exp %0d", i, rdo, 20 + i); end
      total++; if (lat != 32) begin bad++; $display("FAIL div_latency[%0d]: got %0d exp 32", i, lat); end
      total++; if (ba !== 1'b0 || da !== 1'b0) begin bad++; $display("FAIL div_after[%0d]: busy %b done %b exp 0 0", i, ba, da); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f [4];
    logic [31:0] a [4], b [4], e [4];
    int lat, bc; logic [31:0] res; logic [4:0] rdo; logic ba, da;
    f = '{3'd5, 3'd7, 3'd6, 3'd4};
    a = '{32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    b = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    e = '{32'hFFFF_FFFF, 32'h1234, 32'd0, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], 5'(27 + i), lat, bc, res, rdo, ba, da);
      total++; if (res !== e[i]) begin bad++; $display("FAIL spec_result[%0d]: got %h exp %h", i, res, e[i]); end
      total++; if (rdo !== 5'(27 + i)) begin bad++; $display("FAIL spec_rd[%0d]: got %0d exp %0d", i, rdo, 27 + i); end
      total++; if (lat != 0) begin bad++; $display("FAIL spec_latency[%0d]: got %0d exp 0", i, lat); end
      total++; if (bc != 1) begin bad++; $display("FAIL spec_busy_cycles[%0d]: got %0d exp 1", i, bc); end
      total++; if (ba !== 1'b0 || da !== 1'b0) begin bad++; $display("FAIL spec_after[%0d]: busy %b done %b exp 0 0", i, ba, da); end
    end
  endtask

  task automatic test_reset_midop();
    int seen, lat, bc; logic [31:0] res; logic [4:0] rdo; logic ba, da;
    @(negedge clk);
    funct3 = 3'd0; rs1_data = 32'd12345; rs2_data = 32'd678; rd_addr = 5'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b exp 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done: got %b exp 0", done); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL midreset_result: got %h exp 0", result); end
    total++; if (rd_out !== 5'd0) begin bad++; $display("FAIL midreset_rd_out: got %h exp 0", rd_out); end
    @(negedge clk) reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midreset_stray_done: got %0d exp 0", seen); end
    issue(3'd5, 32'd9, 32'd3, 5'd9, lat, bc, res, rdo, ba, da);
    total++; if (res !== 32'd3) begin bad++; $display("FAIL post_reset_result: got %h exp 3", res); end
    total++; if (lat != 32) begin bad++; $display("FAIL post_reset_latency: got %0d exp 32", lat); end
    total++; if (rdo !== 5'd9) begin bad++; $display("FAIL post_reset_rd: got %0d exp 9", rdo); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int lat, bc, elat; logic [31:0] res, a, b, e; logic [4:0] rdo, rd; logic ba, da;
    logic [2:0] f;
    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom_range(0, 31));
      e  = ref_op(f, a, b);
      elat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 0 : 32;
      issue(f, a, b, rd, lat, bc, res, rdo, ba, da);
      total++; if (res !== e) begin bad++; $display("FAIL rand_result[%0d] f=%0d a=%h b=%h: got %h exp %h", i, f, a, b, res, e); end
      total++; if (rdo !== rd) begin bad++; $display("FAIL rand_rd[%0d]: got %0d exp %0d", i, rdo, rd); end
      total++; if (lat != elat) begin bad++; $display("FAIL rand_latency[%0d]: got %0d exp %0d", i, lat, elat); end
    end
  endtask

  task automatic test_start_held();
    int next_free, exp_edge[$];
    logic [31:0] exp_res[$], a, b;
    logic [4:0]  exp_rd[$], rd;
    logic [2:0]  f;
    next_free = 0;
    for (int i = 0; i < 136; i++) begin
      @(negedge clk);
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom_range(1, 100000);
      rd = 5'($urandom_range(0, 31));
      funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
      if (i >= next_free) begin
        exp_edge.push_back(i + 32);
        exp_res.push_back(ref_op(f, a, b));
        exp_rd.push_back(rd);
        next_free = i + 34;
      end
      @(posedge clk); #1;
      if (done) begin
        total++;
        if (exp_edge.size() == 0 || exp_edge[0] != i) begin
          bad++; $display("FAIL held_done_edge: got done at edge %0d, not expected there", i);
        end else begin
          void'(exp_edge.pop_front());
          total++; if (result !== exp_res[0]) begin bad++; $display("FAIL held_result: got %h exp %h", result, exp_res[0]); end
          total++; if (rd_out !== exp_rd[0]) begin bad++; $display("FAIL held_rd: got %0d exp %0d", rd_out, exp_rd[0]); end
          void'(exp_res.pop_front());
          void'(exp_rd.pop_front());
        end
      end
    end
    @(negedge clk) start = 1'b0;
    total++; if (exp_edge.size() != 0) begin bad++; $display("FAIL held_missing_done: got %0d outstanding exp 0", exp_edge.size()); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_reset_midop();
    test_random();
    test_start_held();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
